// File: rtl/lcd_pkg.sv
// Shared LCD constants, timing and refresh
// sequencer state encoding.
package lcd_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned REFRESH_50MS = CLK_HZ / 20;
  localparam int unsigned BYTE_GAP = 2;

  localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
  localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_CHAR = 3'd2;
  localparam logic [2:0] ST_GAP = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  function automatic logic [7:0] line_cmd(
    input logic line
  );
    return line ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
  endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// 32x8 screen buffer, sync write, async read,
// cleared to spaces on reset.
module lcd_char_buffer
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= LCD_CHAR_SPACE;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Repaints both LCD lines from the screen buffer
// through the byte-level write engine handshake.
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = REFRESH_50MS,
  parameter int unsigned GAP_CYCLES = BYTE_GAP
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iWrEn,
  input  logic [4:0] iWrAddr,
  input  logic [7:0] iWrData,
  output logic       oWriteBegin,
  output logic [7:0] oData,
  output logic       oRegisterSelect,
  input  logic       iWriteDone,
  output logic       oFrameDone
);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        line;
  logic [4:0]  idx;
  logic [31:0] gap_cnt;
  logic [31:0] refresh_cnt;
  logic [7:0]  rd_data;
  logic        ack;

  lcd_char_buffer u_buf (
    .clk     (Clock),
    .rst     (Reset),
    .wr_en   (iWrEn),
    .wr_addr (iWrAddr),
    .wr_data (iWrData),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  assign ack = oWriteBegin && iWriteDone;

  // Bytes are launched on the edge that leaves
  // GAP, so the bus stays low exactly GAP_CYCLES.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= ST_IDLE;
      next_state      <= ST_IDLE;
      line            <= 1'b0;
      idx             <= 5'd0;
      gap_cnt         <= 32'd0;
      refresh_cnt     <= 32'd0;
      oWriteBegin     <= 1'b0;
      oData           <= 8'h00;
      oRegisterSelect <= 1'b0;
      oFrameDone      <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (iInitDone) begin
            line            <= 1'b0;
            oData           <= LCD_CMD_LINE0;
            oRegisterSelect <= 1'b0;
            oWriteBegin     <= 1'b1;
            state           <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ack) begin
            oWriteBegin <= 1'b0;
            gap_cnt     <= 32'd0;
            idx         <= {line, 4'd0};
            next_state  <= ST_CHAR;
            state       <= ST_GAP;
          end
        end
        ST_CHAR: begin
          if (ack) begin
            oWriteBegin <= 1'b0;
            gap_cnt     <= 32'd0;
            state       <= ST_GAP;
            if (idx[3:0] != 4'hF) begin
              idx        <= idx + 5'd1;
              next_state <= ST_CHAR;
            end else if (!line) begin
              line       <= 1'b1;
              next_state <= ST_ADDR;
            end else begin
              next_state <= ST_WAIT;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_CYCLES - 1) begin
            state <= next_state;
            unique case (next_state)
              ST_ADDR: begin
                oData           <= line_cmd(line);
                oRegisterSelect <= 1'b0;
                oWriteBegin     <= 1'b1;
              end
              ST_CHAR: begin
                oData           <= rd_data;
                oRegisterSelect <= 1'b1;
                oWriteBegin     <= 1'b1;
              end
              default: begin
                oFrameDone  <= 1'b1;
                refresh_cnt <= 32'd0;
              end
            endcase
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        ST_WAIT: begin
          if (refresh_cnt >= REFRESH_CYCLES - 1) begin
            if (iInitDone) begin
              line            <= 1'b0;
              oData           <= LCD_CMD_LINE0;
              oRegisterSelect <= 1'b0;
              oWriteBegin     <= 1'b1;
              state           <= ST_ADDR;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Scoreboard bench for the LCD refresh sequencer
// with a write engine model on the handshake.
module tb_lcd_refresh_sequencer;
  import lcd_pkg::*;

  localparam int REFRESH = 100;
  localparam int GAP = 2;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         low;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       write_begin;
  logic [7:0] data;
  logic       rs;
  logic       write_done = 1'b0;
  logic       frame_done;

  int tests = 0;
  int fails = 0;
  int ack_delay = 20;
  int fd_cnt = 0;
  int fd_wide = 0;
  int unstable = 0;

  logic [7:0] model_buf [32];
  logic [8:0] exp_q [$];
  obs_t       obs_q [$];

  always #10 clk = ~clk;

  lcd_refresh_sequencer #(
    .REFRESH_CYCLES (REFRESH),
    .GAP_CYCLES     (GAP)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .iInitDone       (init_done),
    .iWrEn           (wr_en),
    .iWrAddr         (wr_addr),
    .iWrData         (wr_data),
    .oWriteBegin     (write_begin),
    .oData           (data),
    .oRegisterSelect (rs),
    .iWriteDone      (write_done),
    .oFrameDone      (frame_done)
  );

  // write engine: ack ack_delay cycles after begin
  initial begin : engine
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      write_done = 1'b0;
      if (rst || !write_begin) begin
        w = 0;
      end else if (w >= ack_delay) begin
        write_done = 1'b1;
        w = 0;
      end else begin
        w++;
      end
    end
  end

  initial begin : monitor
    logic pb, pr, pfd;
    logic [7:0] pd;
    int low;
    obs_t o;
    pb = 0; pr = 0; pfd = 0; pd = 0; low = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 0; pfd = 0; low = 0;
      end else begin
        if (write_begin && !pb) begin
          o.rs = rs; o.data = data; o.low = low;
          obs_q.push_back(o);
        end
        if (write_begin && pb &&
            (data !== pd || rs !== pr))
          unstable++;
        low = write_begin ? 0 : low + 1;
        if (frame_done) begin
          if (pfd) fd_wide++;
          else fd_cnt++;
        end
        pb = write_begin; pd = data;
        pr = rs; pfd = frame_done;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    init_done = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    fd_cnt = 0;
    for (int i = 0; i < 32; i++)
      model_buf[i] = LCD_CHAR_SPACE;
    rst = 1'b0;
  endtask

  task automatic host_write(
    input logic [4:0] a,
    input logic [7:0] d
  );
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_buf[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_frame();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++)
      exp_q.push_back({1'b1, model_buf[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++)
      exp_q.push_back({1'b1, model_buf[i]});
  endtask

  task automatic wait_fd(input int n, input int lim);
    for (int i = 0; i < lim && fd_cnt < n; i++)
      @(negedge clk);
  endtask

  task automatic wait_obs(input int n, input int lim);
    for (int i = 0; i < lim && obs_q.size() < n; i++)
      @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (write_begin !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl begin=%b fd=%b want 0 0",
               write_begin, frame_done);
    end
    tests++;
    if (data !== 8'h00 || rs !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus data=%h rs=%b want 00 0",
               data, rs);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if (write_begin !== 1'b0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL idle_hold begin=%b bytes=%0d want 0 0",
               write_begin, obs_q.size());
    end
  endtask

  task automatic test_frame(input string name);
    obs_t o;
    logic [8:0] e;
    int n;
    push_frame();
    init_done = 1'b1;
    wait_fd(1, 5000);
    init_done = 1'b0;
    repeat (150) @(negedge clk);
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if ({o.rs, o.data} !== e) begin
        fails++;
        $display("FAIL %s byte%0d got %b/%h want %b/%h",
                 name, n, o.rs, o.data, e[8], e[7:0]);
      end
      if (n != 0) begin
        tests++;
        if (o.low !== GAP) begin
          fails++;
          $display("FAIL %s gap%0d got %0d want %0d",
                   name, n, o.low, GAP);
        end
      end
      n++;
    end
    tests++;
    if (n != 34 || obs_q.size() != 0 || fd_cnt != 1) begin
      fails++;
      $display("FAIL %s count got %0d+%0d fd=%0d want 34 fd=1",
               name, n, obs_q.size(), fd_cnt);
    end
  endtask

  task automatic test_default_frame();
    do_reset();
    test_frame("default");
    tests++;
    if (fd_wide != 0) begin
      fails++;
      $display("FAIL fd_width got %0d wide want 0", fd_wide);
    end
  endtask

  task automatic test_host_text();
    string s1, s2;
    s1 = "Hola";
    s2 = "Mundo";
    do_reset();
    for (int i = 0; i < 4; i++)
      host_write(5'(i), s1[i]);
    for (int i = 0; i < 5; i++)
      host_write(5'(16 + i), s2[i]);
    test_frame("text");
  endtask

  task automatic test_inflight_refresh();
    obs_t o;
    logic [8:0] e;
    int n;
    do_reset();
    push_frame();
    init_done = 1'b1;
    wait_obs(7, 5000);
    tests++;
    if (write_begin !== 1'b1 || data !== 8'h20 ||
        rs !== 1'b1) begin
      fails++;
      $display("FAIL inflight got %b/%b/%h want 1/1/20",
               write_begin, rs, data);
    end
    host_write(5'd5, 8'h41);
    push_frame();
    wait_fd(1, 5000);
    wait_obs(44, 5000);
    init_done = 1'b0;
    wait_fd(2, 5000);
    repeat (300) @(negedge clk);
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if ({o.rs, o.data} !== e) begin
        fails++;
        $display("FAIL inflight byte%0d got %b/%h want %b/%h",
                 n, o.rs, o.data, e[8], e[7:0]);
      end
      if (n == 34) begin
        tests++;
        if (o.low !== REFRESH + GAP) begin
          fails++;
          $display("FAIL refresh_gap got %0d want %0d",
                   o.low, REFRESH + GAP);
        end
      end
      n++;
    end
    tests++;
    if (n != 68 || obs_q.size() != 0 || fd_cnt != 2) begin
      fails++;
      $display("FAIL init_drop got %0d+%0d fd=%0d want 68 fd=2",
               n, obs_q.size(), fd_cnt);
    end
  endtask

  task automatic test_ack_delays();
    obs_t o;
    logic [8:0] e;
    int n;
    do_reset();
    ack_delay = 0;
    push_frame();
    push_frame();
    init_done = 1'b1;
    wait_fd(1, 5000);
    ack_delay = 1000;
    wait_obs(35, 5000);
    init_done = 1'b0;
    wait_fd(2, 40000);
    repeat (300) @(negedge clk);
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if ({o.rs, o.data} !== e) begin
        fails++;
        $display("FAIL delay byte%0d got %b/%h want %b/%h",
                 n, o.rs, o.data, e[8], e[7:0]);
      end
      if (n % 34 != 0) begin
        tests++;
        if (o.low !== GAP) begin
          fails++;
          $display("FAIL delay gap%0d got %0d want %0d",
                   n, o.low, GAP);
        end
      end
      n++;
    end
    tests++;
    if (n != 68 || obs_q.size() != 0 || fd_cnt != 2) begin
      fails++;
      $display("FAIL delay count got %0d+%0d fd=%0d want 68 fd=2",
               n, obs_q.size(), fd_cnt);
    end
    tests++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL stable got %0d changes want 0", unstable);
    end
    ack_delay = 20;
  endtask

  task automatic test_reset_mid_char();
    do_reset();
    host_write(5'd0, 8'h58);
    host_write(5'd31, 8'h5A);
    init_done = 1'b1;
    wait_obs(5, 5000);
    tests++;
    if (write_begin !== 1'b1 || rs !== 1'b1) begin
      fails++;
      $display("FAIL midchar_pre got %b/%b want 1/1",
               write_begin, rs);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (write_begin !== 1'b0) begin
      fails++;
      $display("FAIL midchar_rst begin=%b want 0",
               write_begin);
    end
    do_reset();
    test_frame("restart");
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      model_buf[i] = LCD_CHAR_SPACE;
    test_reset();
    test_default_frame();
    test_host_text();
    test_inflight_refresh();
    test_ack_delays();
    test_reset_mid_char();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
